wb_dest_ctrl: RTL and testbench

Writeback-side counterpart of the ALU operand-B select: carries each instruction's result through the EX/MEM and MEM/WB pipeline registers. It picks the destination register with the same opcode classes the operand select uses: rt for I-type, rd for R-type, no write otherwise. It also picks the write data (memory read data for LOAD, ALU result otherwise) and drives the register-file write port. It exports MEM-stage forwarding and load-use information to the hazard/forwarding logic, and honours pipeline stall and flush.

---
 rtl/wb_dest_ctrl_if.sv | 42 ++++
 rtl/wb_dest_ctrl.sv | 130 +++++++++++++
 tb/tb_wb_dest_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/wb_dest_ctrl_if.sv
// wb_dest_ctrl bus: EX-side inputs, data-memory read data,
// MEM forwarding and register-file write port outputs.
`ifndef AWIDTH
`define AWIDTH 32
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif

interface wb_dest_ctrl_if #(
  parameter int RADDR_W = 5
);
  logic                     stall;
  logic                     flush;
  logic                     ex_valid;
  logic [`OPCODE_WIDTH-1:0] ex_opcode;
  logic [RADDR_W-1:0]       ex_rt;
  logic [RADDR_W-1:0]       ex_rd;
  logic [`AWIDTH-1:0]       ex_result;
  logic [`AWIDTH-1:0]       mem_rdata;
  logic                     mem_fwd_en;
  logic [RADDR_W-1:0]       mem_fwd_addr;
  logic [`AWIDTH-1:0]       mem_fwd_data;
  logic                     mem_is_load;
  logic                     wb_en;
  logic [RADDR_W-1:0]       wb_addr;
  logic [`AWIDTH-1:0]       wb_data;

  modport master (
    output stall, flush, ex_valid, ex_opcode,
    output ex_rt, ex_rd, ex_result, mem_rdata,
    input  mem_fwd_en, mem_fwd_addr, mem_fwd_data,
    input  mem_is_load, wb_en, wb_addr, wb_data
  );

  modport slave (
    input  stall, flush, ex_valid, ex_opcode,
    input  ex_rt, ex_rd, ex_result, mem_rdata,
    output mem_fwd_en, mem_fwd_addr, mem_fwd_data,
    output mem_is_load, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/wb_dest_ctrl.sv
// Writeback destination/data select carried through
// the EX/MEM and MEM/WB registers, with MEM forwarding.
`ifndef AWIDTH
`define AWIDTH 32
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif
`ifndef OP_RTYPE
`define OP_RTYPE 6'h00
`define OP_ADDI  6'h08
`define OP_ADDIU 6'h09
`define OP_SLTI  6'h0A
`define OP_SLTIU 6'h0B
`define OP_ANDI  6'h0C
`define OP_ORI   6'h0D
`define OP_LOAD  6'h23
`endif

module wb_dest_ctrl #(
  parameter int RADDR_W = 5
) (
  input logic           clk,
  input logic           rst,
  wb_dest_ctrl_if.slave bus
);
  localparam logic [`OPCODE_WIDTH-1:0] OP_RT  = `OP_RTYPE;
  localparam logic [`OPCODE_WIDTH-1:0] OP_AI  = `OP_ADDI;
  localparam logic [`OPCODE_WIDTH-1:0] OP_AIU = `OP_ADDIU;
  localparam logic [`OPCODE_WIDTH-1:0] OP_SI  = `OP_SLTI;
  localparam logic [`OPCODE_WIDTH-1:0] OP_SIU = `OP_SLTIU;
  localparam logic [`OPCODE_WIDTH-1:0] OP_ANI = `OP_ANDI;
  localparam logic [`OPCODE_WIDTH-1:0] OP_ORI = `OP_ORI;
  localparam logic [`OPCODE_WIDTH-1:0] OP_LD  = `OP_LOAD;

  logic               itype;
  logic               rtype;
  logic               ex_wr;
  logic               ex_ld;
  logic [RADDR_W-1:0] ex_dest;

  logic               m_wr_d, m_wr_q;
  logic               m_ld_d, m_ld_q;
  logic [RADDR_W-1:0] m_dest_d, m_dest_q;
  logic [`AWIDTH-1:0] m_result_d, m_result_q;

  logic               w_wr_d, w_wr_q;
  logic [RADDR_W-1:0] w_dest_d, w_dest_q;
  logic [`AWIDTH-1:0] w_data_d, w_data_q;

  // Opcode class decode and destination pick at EX input
  always_comb begin
    itype = 1'b0;
    rtype = 1'b0;
    case (bus.ex_opcode)
      OP_LD, OP_AI, OP_AIU, OP_SI,
      OP_SIU, OP_ANI, OP_ORI: itype = 1'b1;
      OP_RT:                  rtype = 1'b1;
      default: ;
    endcase
    ex_dest = '0;
    if (itype)
      ex_dest = bus.ex_rt;
    else if (rtype)
      ex_dest = bus.ex_rd;
    ex_wr = bus.ex_valid & (itype | rtype)
          & (ex_dest != '0);
    ex_ld = (bus.ex_opcode == OP_LD);
  end

  // MEM stage next state: flush bubble, stall hold, else advance
  always_comb begin
    m_wr_d     = m_wr_q;
    m_ld_d     = m_ld_q;
    m_dest_d   = m_dest_q;
    m_result_d = m_result_q;
    if (bus.flush) begin
      m_wr_d     = 1'b0;
      m_ld_d     = 1'b0;
      m_dest_d   = '0;
      m_result_d = '0;
    end else if (!bus.stall) begin
      m_wr_d     = ex_wr;
      m_ld_d     = ex_ld;
      m_dest_d   = ex_dest;
      m_result_d = bus.ex_result;
    end
  end

  // WB stage: bubble while MEM is held so it writes once
  always_comb begin
    w_wr_d   = m_wr_q;
    w_dest_d = m_dest_q;
    w_data_d = m_ld_q ? bus.mem_rdata : m_result_q;
    if (bus.stall && !bus.flush) begin
      w_wr_d   = 1'b0;
      w_dest_d = '0;
      w_data_d = '0;
    end
  end

  // Pipeline registers with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      m_wr_q     <= 1'b0;
      m_ld_q     <= 1'b0;
      m_dest_q   <= '0;
      m_result_q <= '0;
      w_wr_q     <= 1'b0;
      w_dest_q   <= '0;
      w_data_q   <= '0;
    end else begin
      m_wr_q     <= m_wr_d;
      m_ld_q     <= m_ld_d;
      m_dest_q   <= m_dest_d;
      m_result_q <= m_result_d;
      w_wr_q     <= w_wr_d;
      w_dest_q   <= w_dest_d;
      w_data_q   <= w_data_d;
    end
  end

  assign bus.mem_fwd_en   = m_wr_q;
  assign bus.mem_fwd_addr = m_dest_q;
  assign bus.mem_fwd_data = m_result_q;
  assign bus.mem_is_load  = m_wr_q & m_ld_q;
  assign bus.wb_en        = w_wr_q;
  assign bus.wb_addr      = w_dest_q;
  assign bus.wb_data      = w_data_q;
endmodule

// File: tb/tb_wb_dest_ctrl.sv
// Directed vector bench for wb_dest_ctrl: one record per
// clock, outputs checked 1 time unit after the rising edge.
module tb_wb_dest_ctrl;
  localparam logic [5:0] RT  = 6'h00;
  localparam logic [5:0] AI  = 6'h08;
  localparam logic [5:0] ORI = 6'h0D;
  localparam logic [5:0] LD  = 6'h23;
  localparam logic [5:0] SW  = 6'h2B;

  typedef struct packed {
    logic        rst, stall, flush, valid;
    logic [5:0]  op;
    logic [4:0]  rt, rd;
    logic [31:0] res, rdata;
  } in_t;

  typedef struct packed {
    logic        fen;
    logic [4:0]  faddr;
    logic [31:0] fdata;
    logic        isld, wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  wb_dest_ctrl_if #(.RADDR_W(5)) bus_if ();

  wb_dest_ctrl #(.RADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  function automatic vec_t v(
    input string nm,
    input logic r, s, f, vl,
    input logic [5:0] op,
    input logic [4:0] rt, rd,
    input logic [31:0] res, rdata,
    input logic fen, input logic [4:0] fa,
    input logic [31:0] fd, input logic il,
    input logic we, input logic [4:0] wa,
    input logic [31:0] wd);
    vec_t x;
    x.name = nm;
    x.i = '{r, s, f, vl, op, rt, rd, res, rdata};
    x.o = '{fen, fa, fd, il, we, wa, wd};
    return x;
  endfunction

  task automatic run(input vec_t x);
    out_t g;
    rst              = x.i.rst;
    bus_if.stall     = x.i.stall;
    bus_if.flush     = x.i.flush;
    bus_if.ex_valid  = x.i.valid;
    bus_if.ex_opcode = x.i.op;
    bus_if.ex_rt     = x.i.rt;
    bus_if.ex_rd     = x.i.rd;
    bus_if.ex_result = x.i.res;
    bus_if.mem_rdata = x.i.rdata;
    @(posedge clk);
    #1;
    g = '{bus_if.mem_fwd_en, bus_if.mem_fwd_addr,
          bus_if.mem_fwd_data, bus_if.mem_is_load,
          bus_if.wb_en, bus_if.wb_addr, bus_if.wb_data};
    nvec++;
    if (g !== x.o) begin
      nerr++;
      $display("FAIL %s: got fwd=%b/%0d/%h ld=%b wb=%b/%0d/%h, want fwd=%b/%0d/%h ld=%b wb=%b/%0d/%h",
               x.name, g.fen, g.faddr, g.fdata, g.isld,
               g.wen, g.waddr, g.wdata,
               x.o.fen, x.o.faddr, x.o.fdata, x.o.isld,
               x.o.wen, x.o.waddr, x.o.wdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //             name       r s f v op  rt  rd  res        rdata        fen fa fd      il we wa wd
    tbl.push_back(v("reset",   1,0,0,0,RT, 0,  0, 32'h0,     32'h0,       0, 0, 32'h0,  0,0, 0,32'h0));
    tbl.push_back(v("rt_in",   0,0,0,1,RT, 9,  8, 32'h1234,  32'h0,       1, 8, 32'h1234,0,0, 0,32'h0));
    tbl.push_back(v("rt_wb",   0,0,0,0,RT, 0,  0, 32'h0,     32'h0,       0, 0, 32'h0,  0,1, 8,32'h1234));
    tbl.push_back(v("addi",    0,0,0,1,AI, 5,  7, 32'h10,    32'h0,       1, 5, 32'h10, 0,0, 0,32'h0));
    tbl.push_back(v("load",    0,0,0,1,LD, 6,  0, 32'h100,   32'h0,       1, 6, 32'h100,1,1, 5,32'h10));
    tbl.push_back(v("load_wb", 0,0,0,0,RT, 0,  0, 32'h0,     32'hDEADBEEF,0, 0, 32'h0,  0,1, 6,32'hDEADBEEF));
    tbl.push_back(v("ori_r0",  0,0,0,1,ORI,0,  3, 32'h55,    32'h0,       0, 0, 32'h55, 0,0, 0,32'h0));
    tbl.push_back(v("sw_rt4",  0,0,0,1,SW, 4,  0, 32'h66,    32'h0,       0, 0, 32'h66, 0,0, 0,32'h55));
    tbl.push_back(v("sw_wb",   0,0,0,0,RT, 0,  0, 32'h0,     32'h0,       0, 0, 32'h0,  0,0, 0,32'h66));
    tbl.push_back(v("fl_pre",  0,0,0,1,RT, 0, 11, 32'hAA,    32'h0,       1,11, 32'hAA, 0,0, 0,32'h0));
    tbl.push_back(v("fl_rd10", 0,0,1,1,RT, 0, 10, 32'hBB,    32'h0,       0, 0, 32'h0,  0,1,11,32'hAA));
    tbl.push_back(v("fl_post", 0,0,0,0,RT, 0,  0, 32'h0,     32'h0,       0, 0, 32'h0,  0,0, 0,32'h0));
    tbl.push_back(v("sf_pre",  0,0,0,1,AI,12,  0, 32'hC0,    32'h0,       1,12, 32'hC0, 0,0, 0,32'h0));
    tbl.push_back(v("sf_both", 0,1,1,1,AI,13,  0, 32'hD0,    32'h0,       0, 0, 32'h0,  0,1,12,32'hC0));
    tbl.push_back(v("sf_post", 0,0,0,0,RT, 0,  0, 32'h0,     32'h0,       0, 0, 32'h0,  0,0, 0,32'h0));
    tbl.push_back(v("ld_r0",   0,0,0,1,LD, 0,  0, 32'h200,   32'h0,       0, 0, 32'h200,0,0, 0,32'h0));
    tbl.push_back(v("ld_r0wb", 0,0,0,0,RT, 0,  0, 32'h0,     32'h0,       0, 0, 32'h0,  0,0, 0,32'h0));
    foreach (tbl[k]) run(tbl[k]);

    // Load held in MEM for three stalled cycles
    run(v("stl_ld",  0,0,0,1,LD, 3, 0, 32'h300, 32'h0,        1, 3,32'h300, 1,0, 0,32'h0));
    for (int k = 0; k < 3; k++)
      run(v("stl_hold",0,1,0,1,RT,0,20,32'h2020,32'hCAFEF00D, 1, 3,32'h300, 1,0, 0,32'h0));
    run(v("stl_rel", 0,0,0,1,RT, 0,20, 32'h2020,32'hCAFEF00D, 1,20,32'h2020,0,1, 3,32'hCAFEF00D));
    run(v("stl_once",0,0,0,0,RT, 0, 0, 32'h0,   32'h0,        0, 0,32'h0,   0,1,20,32'h2020));

    // Reset while two writers are in flight
    run(v("rs_w1",   0,0,0,1,AI, 1, 0, 32'h1,   32'h0,        1, 1,32'h1,   0,0, 0,32'h0));
    run(v("rs_w2",   0,0,0,1,AI, 2, 0, 32'h2,   32'h0,        1, 2,32'h2,   0,1, 1,32'h1));
    run(v("rs_hit",  1,0,0,1,AI, 3, 0, 32'h3,   32'h0,        0, 0,32'h0,   0,0, 0,32'h0));
    run(v("rs_idle", 0,0,0,0,RT, 0, 0, 32'h0,   32'h0,        0, 0,32'h0,   0,0, 0,32'h0));
    run(v("rs_idle2",0,0,0,0,RT, 0, 0, 32'h0,   32'h0,        0, 0,32'h0,   0,0, 0,32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
